// File: rtl/ss_scan_decoder.sv
// ss_scan_decoder: rebuilds the 8-digit hex value from a multiplexed seven-segment scan.
// Ports: CLK100MHZ/rst (async, high); AN/CA..CG/DP scan inputs (active low);
//   digits/blank/dp published frame, frame_valid pulse, seg_err sticky, scan_lost level.
//   Optional macro SS_DP_CAPTURE_EN: DP joins the stability compare and is captured into dp.
module ss_scan_decoder #(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        CLK100MHZ,
   input  logic        rst,
   input  logic [7:0]  AN,
   input  logic        CA,
   input  logic        CB,
   input  logic        CC,
   input  logic        CD,
   input  logic        CE,
   input  logic        CF,
   input  logic        CG,
   input  logic        DP,
   output logic [31:0] digits,
   output logic [7:0]  blank,
   output logic [7:0]  dp,
   output logic        frame_valid,
   output logic        seg_err,
   output logic        scan_lost
);

   localparam int CW = $clog2(STABLE_CYCLES) + 1;
   localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
   localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT_CYCLES);

`ifdef SS_DP_CAPTURE_EN
   localparam int SW = 16;
`else
   localparam int SW = 15;
`endif

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      HOLD
   } state_t;

   // registered sample and its predecessor
   logic [SW-1:0] s_d, s_q, sp_q;

`ifdef SS_DP_CAPTURE_EN
   assign s_d = {AN, CG, CF, CE, CD, CC, CB, CA, DP};
`else
   // DP stays on the port but takes no part in decoding
   logic unused_dp;
   assign unused_dp = DP;
   assign s_d = {AN, CG, CF, CE, CD, CC, CB, CA};
`endif

   logic [7:0] an_s;
   logic [6:0] seg_s;
   logic       same;

   assign an_s  = s_q[SW-1 -: 8];
   assign seg_s = ~s_q[SW-9 -: 7];
   assign same  = (s_q == sp_q);

   // slot index from a single low anode
   logic       slot_ok;
   logic [2:0] idx;

   always_comb begin
      slot_ok = 1'b1;
      idx     = 3'd0;
      case (an_s)
         8'b1111_1110: idx = 3'd0;
         8'b1111_1101: idx = 3'd1;
         8'b1111_1011: idx = 3'd2;
         8'b1111_0111: idx = 3'd3;
         8'b1110_1111: idx = 3'd4;
         8'b1101_1111: idx = 3'd5;
         8'b1011_1111: idx = 3'd6;
         8'b0111_1111: idx = 3'd7;
         default:      slot_ok = 1'b0;
      endcase
   end

   // segment pattern (gfedcba, active high) to hex value
   logic       seg_ok;
   logic       seg_blank;
   logic [3:0] seg_val;

   always_comb begin
      seg_ok    = 1'b1;
      seg_blank = 1'b0;
      seg_val   = 4'h0;
      case (seg_s)
         7'h3F: seg_val = 4'h0;
         7'h06: seg_val = 4'h1;
         7'h5B: seg_val = 4'h2;
         7'h4F: seg_val = 4'h3;
         7'h66: seg_val = 4'h4;
         7'h6D: seg_val = 4'h5;
         7'h7D: seg_val = 4'h6;
         7'h07: seg_val = 4'h7;
         7'h7F: seg_val = 4'h8;
         7'h6F: seg_val = 4'h9;
         7'h77: seg_val = 4'hA;
         7'h7C: seg_val = 4'hB;
         7'h39: seg_val = 4'hC;
         7'h5E: seg_val = 4'hD;
         7'h79: seg_val = 4'hE;
         7'h71: seg_val = 4'hF;
         7'h00: seg_blank = 1'b1;
         default: seg_ok = 1'b0;
      endcase
   end

   // FSM
   state_t        state_d, state_q;
   logic [CW-1:0] cnt_d, cnt_q;
   logic          accept;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (slot_ok) begin
               state_d = SETTLE;
               cnt_d   = CW'(1);
            end
         end
         SETTLE: begin
            if (!slot_ok) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (same) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               cnt_d = CW'(1);
            end
         end
         HOLD: begin
            if (!same) begin
               if (slot_ok) begin
                  state_d = SETTLE;
                  cnt_d   = CW'(1);
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      // accept fires on the cycle the count reaches the threshold
      if (state_d == SETTLE && cnt_d >= CNT_MAX) begin
         accept  = 1'b1;
         state_d = HOLD;
      end
   end

   // shadow frame, seen mask, published outputs, watchdog
   logic [31:0]   shadow_d, shadow_q;
   logic [7:0]    sblank_d, sblank_q;
   logic [7:0]    seen_d, seen_q;
   logic [31:0]   digits_d, digits_q;
   logic [7:0]    blank_d, blank_q;
   logic          fv_d, fv_q;
   logic          err_d, err_q;
   logic [WW-1:0] wd_d, wd_q;
`ifdef SS_DP_CAPTURE_EN
   logic [7:0]    sdp_d, sdp_q;
   logic [7:0]    dp_d, dp_q;
`endif

   always_comb begin
      shadow_d = shadow_q;
      sblank_d = sblank_q;
      seen_d   = seen_q;
      digits_d = digits_q;
      blank_d  = blank_q;
      fv_d     = 1'b0;
      err_d    = err_q;
      wd_d     = wd_q;
`ifdef SS_DP_CAPTURE_EN
      sdp_d    = sdp_q;
      dp_d     = dp_q;
`endif
      if (wd_q != WD_MAX)
         wd_d = wd_q + 1'b1;
      // publish the pre-accept shadow; a same-cycle accept lands in the new frame
      if (seen_q == 8'hFF) begin
         digits_d = shadow_q;
         blank_d  = sblank_q;
         fv_d     = 1'b1;
         seen_d   = 8'h00;
`ifdef SS_DP_CAPTURE_EN
         dp_d     = sdp_q;
`endif
      end
      if (accept) begin
         wd_d = '0;
         if (seg_ok) begin
            shadow_d[{idx, 2'b00} +: 4] = seg_val;
            sblank_d[idx]              = seg_blank;
            seen_d[idx]                = 1'b1;
`ifdef SS_DP_CAPTURE_EN
            sdp_d[idx]                 = ~s_q[0];
`endif
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK100MHZ or posedge rst) begin
      if (rst) begin
         s_q      <= '0;
         sp_q     <= '0;
         state_q  <= IDLE;
         cnt_q    <= '0;
         shadow_q <= '0;
         sblank_q <= 8'hFF;
         seen_q   <= '0;
         digits_q <= '0;
         blank_q  <= 8'hFF;
         fv_q     <= 1'b0;
         err_q    <= 1'b0;
         wd_q     <= '0;
      end else begin
         s_q      <= s_d;
         sp_q     <= s_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         sblank_q <= sblank_d;
         seen_q   <= seen_d;
         digits_q <= digits_d;
         blank_q  <= blank_d;
         fv_q     <= fv_d;
         err_q    <= err_d;
         wd_q     <= wd_d;
      end
   end

`ifdef SS_DP_CAPTURE_EN
   always_ff @(posedge CLK100MHZ or posedge rst) begin
      if (rst) begin
         sdp_q <= '0;
         dp_q  <= '0;
      end else begin
         sdp_q <= sdp_d;
         dp_q  <= dp_d;
      end
   end
   assign dp = dp_q;
`else
   assign dp = 8'h00;
`endif

   assign digits      = digits_q;
   assign blank       = blank_q;
   assign frame_valid = fv_q;
   assign seg_err     = err_q;
   assign scan_lost   = (wd_q == WD_MAX);

endmodule

// File: tb/tb_ss_scan_decoder.sv
// tb_ss_scan_decoder: directed scan sequences for ss_scan_decoder
// (STABLE_CYCLES=16, TIMEOUT_CYCLES=64) with immediate-assertion checks.
module tb_ss_scan_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  AN;
   logic        CA, CB, CC, CD, CE, CF, CG, DP;
   logic [31:0] digits;
   logic [7:0]  blank;
   logic [7:0]  dp;
   logic        frame_valid;
   logic        seg_err;
   logic        scan_lost;

   int total = 0;
   int bad   = 0;
   int fv_cnt = 0;
   int base;

   ss_scan_decoder #(
      .STABLE_CYCLES (16),
      .TIMEOUT_CYCLES(64)
   ) dut (
      .CLK100MHZ  (clk),
      .rst        (rst),
      .AN         (AN),
      .CA         (CA),
      .CB         (CB),
      .CC         (CC),
      .CD         (CD),
      .CE         (CE),
      .CF         (CF),
      .CG         (CG),
      .DP         (DP),
      .digits     (digits),
      .blank      (blank),
      .dp         (dp),
      .frame_valid(frame_valid),
      .seg_err    (seg_err),
      .scan_lost  (scan_lost)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (frame_valid === 1'b1)
         fv_cnt++;

   function automatic logic [6:0] segf(input int v);
      case (v)
         0:  return 7'h3F;
         1:  return 7'h06;
         2:  return 7'h5B;
         3:  return 7'h4F;
         4:  return 7'h66;
         5:  return 7'h6D;
         6:  return 7'h7D;
         7:  return 7'h07;
         8:  return 7'h7F;
         9:  return 7'h6F;
         10: return 7'h77;
         11: return 7'h7C;
         12: return 7'h39;
         13: return 7'h5E;
         14: return 7'h79;
         15: return 7'h71;
         default: return 7'h00;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // pat is active-high gfedcba; dpl = 1 lights the decimal point
   task automatic drive(input int idx, input logic [6:0] pat,
                        input logic dpl, input int n);
      logic [7:0] one;
      one = 8'h01;
      @(negedge clk);
      AN = ~(one << idx);
      {CG, CF, CE, CD, CC, CB, CA} = ~pat;
      DP = ~dpl;
      repeat (n - 1) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      AN  = 8'hFF;
      {CG, CF, CE, CD, CC, CB, CA} = 7'h7F;
      DP  = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_digits", digits, 32'h0);
      chk("rst_blank", {24'h0, blank}, 32'hFF);
      chk("rst_dp", {24'h0, dp}, 32'h0);
      chk("rst_fv", {31'h0, frame_valid}, 32'h0);
      chk("rst_err", {31'h0, seg_err}, 32'h0);
      chk("rst_lost", {31'h0, scan_lost}, 32'h0);

      // scan 00001234
      base = fv_cnt;
      drive(0, segf(4), 1'b0, 100);
      drive(1, segf(3), 1'b0, 100);
      drive(2, segf(2), 1'b0, 100);
      drive(3, segf(1), 1'b0, 100);
      for (int i = 4; i < 7; i++)
         drive(i, segf(0), 1'b0, 100);
      chk("s1_nofv_early", fv_cnt - base, 0);
      drive(7, segf(0), 1'b0, 100);
      chk("s1_fv_once", fv_cnt - base, 1);
      chk("s1_digits", digits, 32'h00001234);
      chk("s1_blank", {24'h0, blank}, 32'h0);
      chk("s1_err", {31'h0, seg_err}, 32'h0);
      chk("s1_dp", {24'h0, dp}, 32'h0);

      // slot 2 held too briefly, then recaptured
      base = fv_cnt;
      for (int i = 0; i < 8; i++)
         drive(i, segf(8 + i), 1'b0, (i == 2) ? 10 : 100);
      chk("s2_nofv", fv_cnt - base, 0);
      chk("s2_digits_kept", digits, 32'h00001234);
      drive(2, segf(10), 1'b0, 100);
      chk("s2_fv", fv_cnt - base, 1);
      chk("s2_digits", digits, 32'hFEDCBA98);

      // invalid pattern on slot 3, blank slot 6
      base = fv_cnt;
      for (int i = 0; i < 8; i++)
         drive(i, (i == 3) ? 7'h55 : ((i == 6) ? 7'h00 : segf(i)),
               1'b0, 100);
      chk("s3_err", {31'h0, seg_err}, 32'h1);
      chk("s3_nofv", fv_cnt - base, 0);
      drive(3, segf(3), 1'b0, 100);
      chk("s3_fv", fv_cnt - base, 1);
      chk("s3_err_sticky", {31'h0, seg_err}, 32'h1);
      chk("s3_digits", digits, 32'h70543210);
      chk("s3_blank", {24'h0, blank}, 32'h40);

      // two anodes low: no accepts, watchdog expires
      base = fv_cnt;
      @(negedge clk);
      AN = 8'b1111_0011;
      {CG, CF, CE, CD, CC, CB, CA} = ~segf(1);
      repeat (199) @(negedge clk);
      chk("s4_lost", {31'h0, scan_lost}, 32'h1);
      chk("s4_nofv", fv_cnt - base, 0);
      drive(0, segf(1), 1'b0, 10);
      chk("s4_lost_pre", {31'h0, scan_lost}, 32'h1);
      repeat (20) @(negedge clk);
      chk("s4_lost_clr", {31'h0, scan_lost}, 32'h0);

      // reset mid-scan after slots 0..4
      for (int i = 1; i < 5; i++)
         drive(i, segf(i + 1), 1'b0, 100);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("s5_rst_digits", digits, 32'h0);
      chk("s5_rst_blank", {24'h0, blank}, 32'hFF);
      chk("s5_rst_fv", {31'h0, frame_valid}, 32'h0);
      chk("s5_rst_err", {31'h0, seg_err}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      base = fv_cnt;
      for (int i = 5; i < 8; i++)
         drive(i, segf(i + 1), (i == 5), 100);
      chk("s5_nofv", fv_cnt - base, 0);
      for (int i = 0; i < 5; i++)
         drive(i, segf(i + 1), 1'b0, 100);
      chk("s5_fv", fv_cnt - base, 1);
      chk("s5_digits", digits, 32'h87654321);
      chk("s5_blank", {24'h0, blank}, 32'h0);
`ifdef SS_DP_CAPTURE_EN
      chk("s5_dp", {24'h0, dp}, 32'h20);
`else
      chk("s5_dp", {24'h0, dp}, 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
